uart: RTL and testbench
=======================

UART -- requirements
Module: uart

Interface
REQ-001 Parameter CMD_WIDTH, default 16: width of cmd_in; SHALL be a multiple of 8.
REQ-002 Parameter READ_WIDTH, default 8: width of read_data; SHALL be a multiple of 8.
REQ-003 Parameter BR, default 115200: baud rate in bits/s.
REQ-004 Parameter CHEAK, default 1: 1 = even parity bit appended on TX and checked on RX; 0 = no parity bit.
REQ-005 Parameter CLK_FREQ, default 100000000: clock frequency in Hz; bit period DIV = CLK_FREQ/BR (integer division, 868 at defaults).
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst_n  input  1  reset; synchronous, active-high despite the name (1 = reset).
REQ-008 cmd_in  input  CMD_WIDTH  command word to transmit; sampled on accept.
REQ-009 cmd_vld  input  1  command valid.
REQ-010 rx  input  1  asynchronous serial input, idle high.
REQ-011 tx  output  1  serial output, idle high, registered.
REQ-012 read_rdy  output  1  one-cycle pulse: read_data holds a newly received word.
REQ-013 read_data  output  READ_WIDTH  last received word.
REQ-014 cmd_rdy  output  1  transmitter can accept a command.

Function
REQ-015 Frame format: 1 start bit (0), 8 data bits LSB first, parity bit if CHEAK=1 (even: XOR of data bits), 1 stop bit (1); each bit lasts exactly DIV clocks.
REQ-016 TX accept: command accepted on a rising edge where cmd_vld=1 and cmd_rdy=1; cmd_in latched that edge; cmd_rdy goes 0 the next cycle.
REQ-017 cmd_vld while cmd_rdy=0 is ignored; holding cmd_vld high across a transmission causes no second accept until cmd_rdy returns to 1.
REQ-018 TX sends CMD_WIDTH/8 bytes back-to-back, most-significant byte first, no idle gap between frames.
REQ-019 TX state machine: IDLE -> START -> DATA(8 bits) -> PARITY (skipped when CHEAK=0) -> STOP -> START of next byte, or IDLE after last byte.
REQ-020 tx goes low on the cycle after accept; cmd_rdy returns to 1 on the cycle after the last stop bit period completes.
REQ-021 rx SHALL pass through a two-flop synchronizer before use.
REQ-022 RX state machine: IDLE -> START on synchronized falling edge; at DIV/2 clocks re-sample; if high, return to IDLE (glitch); else sample each following bit at its centre (every DIV clocks) through DATA, PARITY (if CHEAK=1), STOP, then IDLE.
REQ-023 Parity mismatch or stop bit sampled 0: byte discarded, partial word cleared, no read_rdy; RX returns to IDLE and waits for rx high before the next start.
REQ-024 RX assembles READ_WIDTH/8 valid bytes, first byte received in the most-significant byte; on the last byte's stop sample, read_data updates and read_rdy pulses high for exactly one cycle.
REQ-025 read_data holds its value until the next complete word.
REQ-026 TX and RX operate independently and concurrently; rx activity never affects cmd_rdy or tx.

Reset
REQ-027 While rst_n=1: tx=1, cmd_rdy=0, read_rdy=0, read_data=0, both FSMs in IDLE, counters and shift registers cleared.
REQ-028 cmd_rdy=1 from the first cycle after rst_n returns to 0.
REQ-029 Reset mid-frame aborts TX and RX immediately; tx returns high the next edge; the aborted command is not resumed.

Verification
REQ-030 Defaults, cmd_in=0xCC3F, cmd_vld held 10 cycles -> tx frames 0xCC then 0x3F (both parity 0), 11 bits x 868 = 9548 clocks each, cmd_rdy low exactly 19096 clocks, single accept.
REQ-031 rx driven with frame byte 0xA5, parity 0, stop 1, at 868 clocks/bit -> read_data=0xA5, one-cycle read_rdy at stop-bit centre.
REQ-032 rx frame 0xA5 with parity bit 1 -> no read_rdy, read_data unchanged; next good frame 0x3C -> read_data=0x3C.
REQ-033 rx low pulse of 100 clocks then high -> no reception, RX back in IDLE.
REQ-034 rst_n pulsed to 1 during second TX byte -> tx=1, cmd_rdy=0 during reset, cmd_rdy=1 after release, no further frame bits.
REQ-035 CHEAK=0, cmd_in=0x0001 -> two 10-bit frames (0x00, 0x01), 8680 clocks each.

Source files
------------

// File: rtl/uart.sv
// UART with a multi-byte command transmitter and a multi-byte word receiver.
// Frames are 1 start, 8 data LSB-first, optional even parity and 1 stop bit.
module uart #(
    parameter int unsigned CMD_WIDTH  = 16,
    parameter int unsigned READ_WIDTH = 8,
    parameter int unsigned BR         = 115200,
    parameter int unsigned CHEAK      = 1,
    parameter int unsigned CLK_FREQ   = 100000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CMD_WIDTH-1:0]  cmd_in,
    input  logic                  cmd_vld,
    input  logic                  rx,
    output logic                  tx,
    output logic                  read_rdy,
    output logic [READ_WIDTH-1:0] read_data,
    output logic                  cmd_rdy
);
    localparam int unsigned DIV      = CLK_FREQ / BR;
    localparam int unsigned HALF     = DIV / 2;
    localparam int unsigned CNT_W    = $clog2(DIV + 1);
    localparam int unsigned TX_BYTES = CMD_WIDTH / 8;
    localparam int unsigned RX_BYTES = READ_WIDTH / 8;
    localparam int unsigned TXB_W    = $clog2(TX_BYTES + 1);
    localparam int unsigned RXB_W    = $clog2(RX_BYTES + 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    tx_state_t             tx_state, tx_state_n;
    logic [CNT_W-1:0]      tx_cnt, tx_cnt_n;
    logic [2:0]            tx_bit, tx_bit_n, tx_bit_inc;
    logic [TXB_W-1:0]      tx_byte, tx_byte_n;
    logic [CMD_WIDTH-1:0]  tx_shift, tx_shift_n;
    logic [7:0]            tx_cur;
    logic                  tx_end, tx_n, cmd_rdy_n;

    rx_state_t             rx_state, rx_state_n;
    logic                  rx_s1, rx_s2, rx_d;
    logic [CNT_W-1:0]      rx_cnt, rx_cnt_n;
    logic [2:0]            rx_bit, rx_bit_n;
    logic [7:0]            rx_sh, rx_sh_n;
    logic [RXB_W-1:0]      rx_byte, rx_byte_n;
    logic [READ_WIDTH-1:0] rx_word, rx_word_n, rx_acc, read_data_n;
    logic                  rx_tick, read_rdy_n;

    // TX state and output registers
    always_ff @(posedge clk) begin
        if (rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_byte  <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
            cmd_rdy  <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_byte  <= tx_byte_n;
            tx_shift <= tx_shift_n;
            tx       <= tx_n;
            cmd_rdy  <= cmd_rdy_n;
        end
    end

    // TX next state: current byte is always the top byte of the shift register
    always_comb begin
        tx_cur     = tx_shift[CMD_WIDTH-1 -: 8];
        tx_end     = (tx_cnt == CNT_W'(DIV - 1));
        tx_bit_inc = tx_bit + 3'd1;
        tx_state_n = tx_state;
        tx_cnt_n   = (tx_state == TX_IDLE || tx_end) ? '0 : tx_cnt + CNT_W'(1);
        tx_bit_n   = tx_bit;
        tx_byte_n  = tx_byte;
        tx_shift_n = tx_shift;
        tx_n       = tx;
        cmd_rdy_n  = cmd_rdy;
        case (tx_state)
            TX_IDLE: begin
                tx_n      = 1'b1;
                cmd_rdy_n = 1'b1;
                if (cmd_vld && cmd_rdy) begin
                    tx_state_n = TX_START;
                    tx_n       = 1'b0;
                    cmd_rdy_n  = 1'b0;
                    tx_shift_n = cmd_in;
                    tx_byte_n  = '0;
                end
            end
            TX_START: begin
                if (tx_end) begin
                    tx_state_n = TX_DATA;
                    tx_bit_n   = '0;
                    tx_n       = tx_cur[0];
                end
            end
            TX_DATA: begin
                if (tx_end) begin
                    if (tx_bit == 3'd7) begin
                        if (CHEAK != 0) begin
                            tx_state_n = TX_PARITY;
                            tx_n       = ^tx_cur;
                        end else begin
                            tx_state_n = TX_STOP;
                            tx_n       = 1'b1;
                        end
                    end else begin
                        tx_bit_n = tx_bit_inc;
                        tx_n     = tx_cur[tx_bit_inc];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_end) begin
                    tx_state_n = TX_STOP;
                    tx_n       = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_end) begin
                    if (tx_byte == TXB_W'(TX_BYTES - 1)) begin
                        tx_state_n = TX_IDLE;
                        tx_n       = 1'b1;
                        cmd_rdy_n  = 1'b1;
                    end else begin
                        tx_state_n = TX_START;
                        tx_n       = 1'b0;
                        tx_byte_n  = tx_byte + TXB_W'(1);
                        tx_shift_n = tx_shift << 8;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // Two-flop synchronizer plus delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    // RX state and output registers
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_sh     <= '0;
            rx_byte   <= '0;
            rx_word   <= '0;
            read_data <= '0;
            read_rdy  <= 1'b0;
        end else begin
            rx_state  <= rx_state_n;
            rx_cnt    <= rx_cnt_n;
            rx_bit    <= rx_bit_n;
            rx_sh     <= rx_sh_n;
            rx_byte   <= rx_byte_n;
            rx_word   <= rx_word_n;
            read_data <= read_data_n;
            read_rdy  <= read_rdy_n;
        end
    end

    // RX next state: half-bit check of the start bit, then centre sampling
    always_comb begin
        rx_tick     = (rx_state == RX_START) ? (rx_cnt == CNT_W'(HALF - 1))
                                             : (rx_cnt == CNT_W'(DIV - 1));
        rx_acc      = (rx_word << 8) | READ_WIDTH'(rx_sh);
        rx_state_n  = rx_state;
        rx_cnt_n    = (rx_state == RX_IDLE || rx_tick) ? '0 : rx_cnt + CNT_W'(1);
        rx_bit_n    = rx_bit;
        rx_sh_n     = rx_sh;
        rx_byte_n   = rx_byte;
        rx_word_n   = rx_word;
        read_data_n = read_data;
        read_rdy_n  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_d && !rx_s2) rx_state_n = RX_START;
            end
            RX_START: begin
                if (rx_tick) begin
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                    rx_bit_n   = '0;
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_sh_n = {rx_s2, rx_sh[7:1]};
                    if (rx_bit == 3'd7) rx_state_n = (CHEAK != 0) ? RX_PARITY : RX_STOP;
                    else                rx_bit_n   = rx_bit + 3'd1;
                end
            end
            RX_PARITY: begin
                if (rx_tick) begin
                    if (rx_s2 != ^rx_sh) begin
                        rx_state_n = RX_IDLE;
                        rx_word_n  = '0;
                        rx_byte_n  = '0;
                    end else begin
                        rx_state_n = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    rx_state_n = RX_IDLE;
                    if (!rx_s2) begin
                        rx_word_n = '0;
                        rx_byte_n = '0;
                    end else if (rx_byte == RXB_W'(RX_BYTES - 1)) begin
                        read_data_n = rx_acc;
                        read_rdy_n  = 1'b1;
                        rx_word_n   = '0;
                        rx_byte_n   = '0;
                    end else begin
                        rx_word_n = rx_acc;
                        rx_byte_n = rx_byte + RXB_W'(1);
                    end
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart.sv
// Bench for uart: directed and random frames against a frame-level model.
module tb_uart;
    localparam int DIV = 100000000 / 115200;

    logic        clk;
    logic        rst_n;
    logic [15:0] cmd_in0, cmd_in1;
    logic        cmd_vld0, cmd_vld1;
    logic        rx0, rx1;
    logic        tx0, tx1;
    logic        read_rdy0, read_rdy1;
    logic [7:0]  read_data0, read_data1;
    logic        cmd_rdy0, cmd_rdy1;

    int tests = 0;
    int fails = 0;

    uart #(.CHEAK(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in0), .cmd_vld(cmd_vld0), .rx(rx0),
        .tx(tx0), .read_rdy(read_rdy0), .read_data(read_data0), .cmd_rdy(cmd_rdy0)
    );

    uart #(.CHEAK(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in1), .cmd_vld(cmd_vld1), .rx(rx1),
        .tx(tx1), .read_rdy(read_rdy1), .read_data(read_data1), .cmd_rdy(cmd_rdy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #(3000000 * 1ns);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_tx(input int w);
        return (w == 1) ? tx1 : tx0;
    endfunction

    function automatic logic get_rdy(input int w);
        return (w == 1) ? cmd_rdy1 : cmd_rdy0;
    endfunction

    task automatic set_cmd(input int w, input logic v, input logic [15:0] c);
        if (w == 1) begin cmd_vld1 = v; cmd_in1 = c; end
        else        begin cmd_vld0 = v; cmd_in0 = c; end
    endtask

    // Send one 16-bit command and compare tx every cycle against the ideal waveform
    task automatic tx_run(input int w, input logic [15:0] cmd, input bit par, input string tag);
        bit         exp_bits[$];
        logic [7:0] b;
        int         total, bad, first_bad, low_cycles, waited, idle_low;
        for (int k = 0; k < 2; k++) begin
            b = 8'(cmd >> (8 * (1 - k)));
            exp_bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
            if (par) exp_bits.push_back(^b);
            exp_bits.push_back(1'b1);
        end
        total  = exp_bits.size() * DIV;
        waited = 0;
        while (get_rdy(w) !== 1'b1 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        check({tag, " cmd_rdy before send"}, 32'(get_rdy(w)), 32'd1);
        set_cmd(w, 1'b1, cmd);
        @(posedge clk); #1;
        bad = 0; first_bad = -1; low_cycles = 0;
        for (int t = 0; t < total; t++) begin
            if (get_tx(w) !== exp_bits[t / DIV]) begin
                if (bad == 0) first_bad = t;
                bad++;
            end
            if (get_rdy(w) === 1'b0) low_cycles++;
            if (t == 8) set_cmd(w, 1'b0, cmd);
            @(posedge clk); #1;
        end
        check($sformatf("%s tx bad cycles (first at %0d)", tag, first_bad), 32'(bad), 32'd0);
        check({tag, " cmd_rdy low cycles"}, 32'(low_cycles), 32'(total));
        check({tag, " cmd_rdy back high"}, 32'(get_rdy(w)), 32'd1);
        idle_low = 0;
        for (int t = 0; t < 30; t++) begin
            if (get_tx(w) !== 1'b1) idle_low++;
            @(posedge clk); #1;
        end
        check({tag, " tx idle after command"}, 32'(idle_low), 32'd0);
    endtask

    // Drive one frame on rx0 and record read_rdy pulses relative to the start bit
    task automatic rx_frame(input logic [7:0] d, input bit pbit, input bit sbit,
                            output int pulses, output int at);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        bits.push_back(pbit);
        bits.push_back(sbit);
        pulses = 0; at = -1;
        for (int j = 0; j < bits.size(); j++) begin
            for (int c = 0; c < DIV; c++) begin
                rx0 = bits[j];
                @(posedge clk); #1;
                if (read_rdy0 === 1'b1) begin
                    pulses++;
                    if (at < 0) at = j * DIV + c + 1;
                end
            end
        end
        rx0 = 1'b1;
        for (int c = 0; c < 150; c++) begin
            @(posedge clk); #1;
            if (read_rdy0 === 1'b1) begin
                pulses++;
                if (at < 0) at = 11 * DIV + c + 1;
            end
        end
    endtask

    task automatic rx_good(input logic [7:0] d, input string tag);
        int pulses, at;
        bit in_win;
        rx_frame(d, ^d, 1'b1, pulses, at);
        in_win = (at >= 10 * DIV + DIV / 4) && (at <= 10 * DIV + (3 * DIV) / 4);
        check({tag, " read_rdy pulse count"}, 32'(pulses), 32'd1);
        check($sformatf("%s read_rdy near stop centre (at %0d)", tag, at), 32'(in_win), 32'd1);
        check({tag, " read_data"}, 32'(read_data0), 32'(d));
    endtask

    initial begin
        logic [7:0]  r1, r2, last;
        logic [15:0] wrand, wrst;
        int          pulses, at, lows, highs;

        rst_n = 1'b1;
        cmd_in0 = '0; cmd_vld0 = 1'b0; rx0 = 1'b1;
        cmd_in1 = '0; cmd_vld1 = 1'b0; rx1 = 1'b1;
        r1 = 8'($urandom_range(0, 255));
        while (r1 == 8'hA5 || r1 == 8'h3C) r1 = 8'($urandom_range(0, 255));
        r2    = 8'($urandom_range(0, 255));
        wrand = 16'($urandom);
        wrst  = 16'($urandom);

        repeat (3) @(posedge clk);
        #1;
        check("reset tx", 32'(tx0), 32'd1);
        check("reset cmd_rdy", 32'(cmd_rdy0), 32'd0);
        check("reset read_rdy", 32'(read_rdy0), 32'd0);
        check("reset read_data", 32'(read_data0), 32'd0);
        check("reset tx (no parity)", 32'(tx1), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("cmd_rdy first cycle after reset", 32'(cmd_rdy0), 32'd1);
        check("cmd_rdy first cycle after reset (no parity)", 32'(cmd_rdy1), 32'd1);

        fork
            begin
                tx_run(0, 16'hCC3F, 1'b1, "tx CC3F");
                tx_run(0, wrand, 1'b1, $sformatf("tx random %04h", wrand));
            end
            begin
                tx_run(1, 16'h0001, 1'b0, "tx no-parity 0001");
            end
            begin
                rx_good(8'hA5, "rx A5");
                rx_good(r1, $sformatf("rx random %02h", r1));
                rx_frame(8'hA5, 1'b1, 1'b1, pulses, at);
                check("rx A5 bad parity read_rdy count", 32'(pulses), 32'd0);
                check("rx A5 bad parity read_data kept", 32'(read_data0), 32'(r1));
                rx_frame(r2, ^r2, 1'b0, pulses, at);
                check("rx bad stop read_rdy count", 32'(pulses), 32'd0);
                check("rx bad stop read_data kept", 32'(read_data0), 32'(r1));
                pulses = 0;
                rx0 = 1'b0;
                repeat (100) begin
                    @(posedge clk); #1;
                    if (read_rdy0 === 1'b1) pulses++;
                end
                rx0 = 1'b1;
                repeat (2 * DIV) begin
                    @(posedge clk); #1;
                    if (read_rdy0 === 1'b1) pulses++;
                end
                check("rx glitch read_rdy count", 32'(pulses), 32'd0);
                rx_good(8'h3C, "rx 3C after glitch");
            end
        join

        last = 8'h3C;
        check("read_data holds between words", 32'(read_data0), 32'(last));

        // Reset during the second byte of a command
        set_cmd(0, 1'b1, wrst);
        @(posedge clk); #1;
        set_cmd(0, 1'b0, wrst);
        check("reset test accepted", 32'(cmd_rdy0), 32'd0);
        repeat (14 * DIV) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid-frame reset tx high", 32'(tx0), 32'd1);
        check("mid-frame reset cmd_rdy low", 32'(cmd_rdy0), 32'd0);
        check("mid-frame reset read_data cleared", 32'(read_data0), 32'd0);
        highs = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (tx0 === 1'b1 && cmd_rdy0 === 1'b0) highs++;
        end
        check("held reset tx high / cmd_rdy low", 32'(highs), 32'd3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("cmd_rdy after mid-frame reset", 32'(cmd_rdy0), 32'd1);
        lows = 0;
        repeat (2 * DIV) begin
            if (tx0 !== 1'b1 || cmd_rdy0 !== 1'b1) lows++;
            @(posedge clk); #1;
        end
        check("aborted command not resumed", 32'(lows), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
